// File: rtl/uart_tx_core.sv
// UART transmitter core: one serial bit per clk edge, optional parity, one or two stop bits.
// Outputs decode only from registered state, so no input reaches tx_out/busy/tx_done combinationally.
module uart_tx_core #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  stop2,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  tx_done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  stop2_q, stop2_d;
   logic                  last_stop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
      end
   end

   // The parity bit is resolved at capture time because the shift register is consumed during DATA.
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      last_stop = (state_q == STOP2) || ((state_q == STOP1) && !stop2_q);

      case (state_q)
         IDLE:   state_d = IDLE;
         START: begin
            cnt_d   = '0;
            state_d = DATA;
         end
         DATA: begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = par_en_q ? PARITY : STOP1;
            end
         end
         PARITY: state_d = STOP1;
         STOP1:  state_d = stop2_q ? STOP2 : IDLE;
         STOP2:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (data_valid && ((state_q == IDLE) || last_stop)) begin
         sh_d      = p_data;
         par_en_d  = par_en;
         par_bit_d = (^p_data) ^ par_typ;
         stop2_d   = stop2;
         state_d   = START;
      end
   end

   always_comb begin
      tx_out  = 1'b1;
      busy    = 1'b1;
      tx_done = last_stop;
      case (state_q)
         IDLE:   busy   = 1'b0;
         START:  tx_out = 1'b0;
         DATA:   tx_out = sh_q[0];
         PARITY: tx_out = par_bit_q;
         default: tx_out = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: frame-level queue model checked every cycle, plus literal frame patterns.
module tb_uart_tx_core;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid, par_en, par_typ, stop2;
   logic       tx_out, busy, tx_done;
   logic [4:0] pd5;
   logic       dv5, pe5, pt5, s25;
   logic       tx5, busy5, done5;

   int  tests = 0;
   int  fails = 0;
   bit  run   = 1'b0;

   always #5 clk = ~clk;

   uart_tx_core #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
      .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
   );

   uart_tx_core #(.DATA_WIDTH(5), .CNT_WIDTH(3)) dut5 (
      .clk(clk), .rst(rst), .p_data(pd5), .data_valid(dv5),
      .par_en(pe5), .par_typ(pt5), .stop2(s25),
      .tx_out(tx5), .busy(busy5), .tx_done(done5)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // A whole frame as a list of line cycles: start, data LSB first, optional parity, stop bit(s).
   function automatic void build(input int w, input logic [8:0] d, input logic pe, input logic pt,
                                 input logic s2, output logic [15:0] txb, output logic [15:0] dnb,
                                 output int len);
      logic p;
      txb = '0;
      dnb = '0;
      len = 0;
      txb[len] = 1'b0; len++;
      p = pt;
      for (int i = 0; i < w; i++) begin
         txb[len] = d[i]; len++;
         p = p ^ d[i];
      end
      if (pe) begin txb[len] = p; len++; end
      txb[len] = 1'b1; len++;
      if (s2) begin txb[len] = 1'b1; len++; end
      dnb[len-1] = 1'b1;
   endfunction

   typedef struct packed { logic tx; logic done; } ent_t;
   ent_t        q8[$];
   ent_t        q5[$];
   logic        cap8, cap5;
   logic [15:0] tb8, db8, tb5, db5;
   int          n8, n5;

   // Queue head is the cycle currently on the line; empty means idle.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q8.delete();
      end else begin
         cap8 = data_valid && ((q8.size() == 0) || q8[0].done);
         if (q8.size() > 0) void'(q8.pop_front());
         if (cap8) begin
            build(8, {1'b0, p_data}, par_en, par_typ, stop2, tb8, db8, n8);
            for (int i = 0; i < n8; i++) q8.push_back('{tb8[i], db8[i]});
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q5.delete();
      end else begin
         cap5 = dv5 && ((q5.size() == 0) || q5[0].done);
         if (q5.size() > 0) void'(q5.pop_front());
         if (cap5) begin
            build(5, {4'b0, pd5}, pe5, pt5, s25, tb5, db5, n5);
            for (int i = 0; i < n5; i++) q5.push_back('{tb5[i], db5[i]});
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("cyc8_tx",   tx_out,  (q8.size() == 0) ? 1'b1 : q8[0].tx);
         chk("cyc8_busy", busy,    (q8.size() != 0));
         chk("cyc8_done", tx_done, (q8.size() == 0) ? 1'b0 : q8[0].done);
         chk("cyc5_tx",   tx5,     (q5.size() == 0) ? 1'b1 : q5[0].tx);
         chk("cyc5_busy", busy5,   (q5.size() != 0));
         chk("cyc5_done", done5,   (q5.size() == 0) ? 1'b0 : q5[0].done);
      end
   end

   // Launch one frame, scramble inputs after capture, and record n cycles plus the idle cycle after.
   task automatic send(input bit w5, input logic [7:0] d, input logic pe, input logic pt,
                       input logic s2, input int n, output logic [15:0] seq,
                       output logic [15:0] dn, output logic all_busy, output logic idle_ok);
      @(negedge clk);
      if (w5) begin
         pd5 = d[4:0]; pe5 = pe; pt5 = pt; s25 = s2; dv5 = 1'b1;
      end else begin
         p_data = d; par_en = pe; par_typ = pt; stop2 = s2; data_valid = 1'b1;
      end
      seq = '0; dn = '0; all_busy = 1'b1; idle_ok = 1'b0;
      for (int i = 1; i <= n + 1; i++) begin
         @(negedge clk);
         if (i <= n) begin
            seq      = {seq[14:0], w5 ? tx5 : tx_out};
            dn       = {dn[14:0], w5 ? done5 : tx_done};
            all_busy = all_busy & (w5 ? busy5 : busy);
         end else begin
            idle_ok = w5 ? (tx5 && !busy5 && !done5) : (tx_out && !busy && !tx_done);
         end
         if (i == 1) begin
            if (w5) begin
               dv5 = 1'b0; pd5 = ~d[4:0]; pe5 = ~pe; pt5 = ~pt; s25 = ~s2;
            end else begin
               data_valid = 1'b0; p_data = ~d; par_en = ~pe; par_typ = ~pt; stop2 = ~s2;
            end
         end
      end
   endtask

   logic [15:0] seq, dn;
   logic        all_b, idle_ok;
   logic [31:0] seq2, dn2;

   initial begin
      rst = 1'b0;
      p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
      pd5 = '0; dv5 = 1'b0; pe5 = 1'b0; pt5 = 1'b0; s25 = 1'b0;
      #12;
      chk("rst_tx",   tx_out,  1'b1);
      chk("rst_busy", busy,    1'b0);
      chk("rst_done", tx_done, 1'b0);
      chk("rst5_tx",  tx5,     1'b1);
      @(negedge clk);
      rst = 1'b1;
      run = 1'b1;
      repeat (2) @(negedge clk);

      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 10, seq, dn, all_b, idle_ok);
      chk("a5_bits", seq, 10'b0101001011);
      chk("a5_done", dn,  10'b0000000001);
      chk("a5_busy", all_b, 1'b1);
      chk("a5_idle", idle_ok, 1'b1);

      send(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 11, seq, dn, all_b, idle_ok);
      chk("a5_even_bits", seq, 11'b01010010101);
      chk("a5_even_done", dn,  11'b00000000001);
      chk("a5_even_idle", idle_ok, 1'b1);

      send(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 11, seq, dn, all_b, idle_ok);
      chk("a5_odd_bits", seq, 11'b01010010111);

      send(1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 12, seq, dn, all_b, idle_ok);
      chk("x07_bits", seq, 12'b011100000011);
      chk("x07_done", dn,  12'b000000000001);
      chk("x07_busy", all_b, 1'b1);
      chk("x07_idle", idle_ok, 1'b1);

      send(1'b1, 8'h1F, 1'b1, 1'b0, 1'b0, 8, seq, dn, all_b, idle_ok);
      chk("w5_bits", seq, 8'b01111111);
      chk("w5_done", dn,  8'b00000001);
      chk("w5_idle", idle_ok, 1'b1);

      // Back-to-back frames with data_valid held high and a stray word mid-frame.
      @(negedge clk);
      p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
      seq2 = '0; dn2 = '0; all_b = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         if (i <= 20) begin
            seq2  = {seq2[30:0], tx_out};
            dn2   = {dn2[30:0], tx_done};
            all_b = all_b & busy;
         end else begin
            chk("b2b_idle_busy", busy, 1'b0);
         end
         if (i == 1)  p_data = 8'h33;
         if (i == 10) p_data = 8'h0F;
         if (i == 11) data_valid = 1'b0;
      end
      chk("b2b_bits", seq2, 20'b01010101010111100001);
      chk("b2b_done", dn2,  20'b00000000010000000001);
      chk("b2b_busy", all_b, 1'b1);

      // Reset during the 4th data bit of an 0xA5 frame.
      @(negedge clk);
      p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_tx_before_rst", tx_out, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_tx",   tx_out,  1'b1);
      chk("mid_rst_busy", busy,    1'b0);
      chk("mid_rst_done", tx_done, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_line", {busy, tx_out}, 2'b01);
      end

      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 10, seq, dn, all_b, idle_ok);
      chk("post_rst_frame", seq, 10'b0101001011);

      run = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
